// File: rtl/icache_prefetch_responder.sv
// Instruction-prefetch responder: fetches one 64-byte line from L2 as 16 word reads and streams them back in order.
// Optional build macro PREFETCH_PERF_CNT_EN adds saturating line-done / line-aborted counters.
module icache_prefetch_responder #(
  parameter int ADDR_W          = 19,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prefetch_req,
  input  logic [ADDR_W-1:0] prefetch_addr,
  output logic              prefetch_gnt,
  output logic              prefetch_r_valid,
  output logic [31:0]       prefetch_r_data,
  output logic              prefetch_done,
  output logic              prefetch_busy,
  input  logic              prefetch_abort,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_gnt,
  input  logic              l2_r_valid,
  input  logic [31:0]       l2_r_data
`ifdef PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lines_done,
  output logic [31:0]       perf_lines_aborted
`endif
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int LINE_W = ADDR_W - 6;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [4:0]        issue_cnt_q, issue_cnt_d;
  logic [4:0]        ret_cnt_q, ret_cnt_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic              r_valid_q, r_valid_d;
  logic [31:0]       r_data_q, r_data_d;
  logic              done_q, done_d;

  logic grant_fire;
  logic rsp_take;
  logic forward;
  logic abort_hit;
  logic unused_addr_bits;

  assign unused_addr_bits = ^prefetch_addr[5:0];

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    issue_cnt_d   = issue_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    r_valid_d     = 1'b0;
    r_data_d      = r_data_q;
    done_d        = 1'b0;
    prefetch_gnt  = 1'b0;
    l2_req        = 1'b0;
    l2_addr       = '0;
    abort_hit     = 1'b0;
    forward       = 1'b0;
    // A response with nothing outstanding is ignored rather than counted.
    rsp_take      = l2_r_valid && (outstanding_q != '0);

    case (state_q)
      IDLE: begin
        prefetch_gnt = prefetch_req & ~prefetch_abort;
        if (prefetch_gnt) begin
          line_d      = prefetch_addr[ADDR_W-1:6];
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        l2_req  = (outstanding_q != OUT_W'(MAX_OUTSTANDING));
        l2_addr = {line_q, issue_cnt_q[3:0], 2'b00};
        if (prefetch_abort) begin
          abort_hit = 1'b1;
          state_d   = FLUSH;
        end else begin
          forward = rsp_take;
          if (l2_req && l2_gnt) begin
            issue_cnt_d = issue_cnt_q + 5'd1;
            if (issue_cnt_q == 5'd15) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (prefetch_abort) begin
          abort_hit = 1'b1;
          state_d   = FLUSH;
        end else begin
          forward = rsp_take;
          // done_q holds the pulse for one cycle while still busy, then IDLE.
          if (done_q) state_d = IDLE;
          else if (ret_cnt_q == 5'd16) done_d = 1'b1;
        end
      end
      FLUSH: begin
        if ((outstanding_q == '0) && !l2_r_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (forward) begin
      r_valid_d = 1'b1;
      r_data_d  = l2_r_data;
      ret_cnt_d = ret_cnt_q + 5'd1;
    end
  end

  // A coincident abort still counts the grant: L2 has accepted that read.
  assign grant_fire = l2_req && l2_gnt;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({grant_fire, rsp_take})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      line_q        <= '0;
      issue_cnt_q   <= '0;
      ret_cnt_q     <= '0;
      outstanding_q <= '0;
      r_valid_q     <= 1'b0;
      r_data_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      issue_cnt_q   <= issue_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
      outstanding_q <= outstanding_d;
      r_valid_q     <= r_valid_d;
      r_data_q      <= r_data_d;
      done_q        <= done_d;
    end
  end

  assign prefetch_r_valid = r_valid_q;
  assign prefetch_r_data  = r_data_q;
  assign prefetch_done    = done_q;
  assign prefetch_busy    = (state_q != IDLE);

`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0] perf_done_q, perf_done_d;
  logic [31:0] perf_abort_q, perf_abort_d;

  always_comb begin
    perf_done_d  = perf_done_q;
    perf_abort_d = perf_abort_q;
    if (done_q && (perf_done_q != '1))     perf_done_d  = perf_done_q + 32'd1;
    if (abort_hit && (perf_abort_q != '1)) perf_abort_d = perf_abort_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_done_q  <= '0;
      perf_abort_q <= '0;
    end else begin
      perf_done_q  <= perf_done_d;
      perf_abort_q <= perf_abort_d;
    end
  end

  assign perf_lines_done    = perf_done_q;
  assign perf_lines_aborted = perf_abort_q;
`endif

  a_no_orphan_response: assert property (@(posedge clk) disable iff (rst)
    !(l2_r_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_icache_prefetch_responder.sv
// Randomized self-checking bench for icache_prefetch_responder: in-order L2 model plus a line-level reference model.
module tb_icache_prefetch_responder;
  localparam int ADDR_W = 19;
  localparam int MAXO   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              prefetch_req = 1'b0;
  logic [ADDR_W-1:0] prefetch_addr = '0;
  logic              prefetch_gnt;
  logic              prefetch_r_valid;
  logic [31:0]       prefetch_r_data;
  logic              prefetch_done;
  logic              prefetch_busy;
  logic              prefetch_abort = 1'b0;
  logic              l2_req;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_gnt = 1'b0;
  logic              l2_r_valid = 1'b0;
  logic [31:0]       l2_r_data = '0;
`ifdef PREFETCH_PERF_CNT_EN
  logic [31:0]       perf_lines_done;
  logic [31:0]       perf_lines_aborted;
`endif

  always #5 clk = ~clk;

  icache_prefetch_responder #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .prefetch_req(prefetch_req), .prefetch_addr(prefetch_addr),
    .prefetch_gnt(prefetch_gnt), .prefetch_r_valid(prefetch_r_valid),
    .prefetch_r_data(prefetch_r_data), .prefetch_done(prefetch_done),
    .prefetch_busy(prefetch_busy), .prefetch_abort(prefetch_abort),
    .l2_req(l2_req), .l2_addr(l2_addr), .l2_gnt(l2_gnt),
    .l2_r_valid(l2_r_valid), .l2_r_data(l2_r_data)
`ifdef PREFETCH_PERF_CNT_EN
    , .perf_lines_done(perf_lines_done), .perf_lines_aborted(perf_lines_aborted)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- L2 model and stimulus knobs ----------------
  typedef struct { logic [31:0] data; int due; } l2_rsp_t;
  l2_rsp_t l2_q[$];
  int  cyc = 0;
  int  lat_min = 1, lat_max = 1, gnt_pct = 100, abort_pct = 0;
  int  abort_mode = 0;
  bit  abort_fired = 0;
  bit  idx_data = 0;
  int  d_grants = 0, d_rets = 0, max_pend = 0;
  bit  drv_rst = 1, drv_req = 0, drv_abort = 0;
  logic [ADDR_W-1:0] drv_addr = '0;

  function automatic logic [31:0] l2_word(input logic [ADDR_W-1:0] a);
    if (idx_data) return {28'd0, a[5:2]};
    return {a[ADDR_W-1:6], a[5:2], 15'h2A5B} ^ 32'hC3A5_0F96;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-7:0] ln, input int k);
    return {ln, 4'(k), 2'b00};
  endfunction

  // Drive one cycle at the falling edge; the L2 answers strictly in order after its latency.
  task automatic tick();
    bit popped;
    @(negedge clk);
    cyc++;
    rst           = drv_rst;
    prefetch_req  = drv_req;
    prefetch_addr = drv_addr;
    prefetch_abort = 1'b0;
    if (abort_mode == 1 && !abort_fired && prefetch_busy && d_grants == 6 && d_rets == 3) begin
      prefetch_abort = 1'b1;
      abort_fired = 1;
    end
    popped = 0;
    l2_r_valid = 1'b0;
    l2_r_data  = '0;
    if (drv_rst) l2_q.delete();
    else if (l2_q.size() > 0 && l2_q[0].due <= cyc) begin
      l2_r_valid = 1'b1;
      l2_r_data  = l2_q[0].data;
      l2_q.delete(0);
      d_rets++;
      popped = 1;
    end
    if (abort_mode == 2 && popped && d_rets == 16) prefetch_abort = 1'b1;
    if (abort_mode == 3) prefetch_abort = ($urandom_range(99) < abort_pct);
    if (drv_abort) prefetch_abort = 1'b1;
    l2_gnt = ($urandom_range(99) < gnt_pct);
    if (abort_mode == 1 && prefetch_abort) l2_gnt = 1'b0;
    if (!drv_rst && l2_req && l2_gnt) begin
      l2_q.push_back('{l2_word(l2_addr), cyc + int'($urandom_range(lat_max, lat_min))});
      d_grants++;
    end
    if (l2_q.size() > max_pend) max_pend = l2_q.size();
    #2;
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  typedef enum int {M_IDLE, M_ISSUE, M_DRAIN, M_FLUSH} mph_t;
  mph_t              ph = M_IDLE;
  logic [ADDR_W-7:0] m_line = '0;
  int                m_grants = 0, m_rets = 0, m_pend = 0, done_at = -1, mcyc = 0;
  int                m_dones = 0, m_aborts = 0;
  bit                m_rv = 0;
  logic [31:0]       m_rd = '0;
  logic [31:0]       seen_words[$];
  logic [ADDR_W-1:0] seen_addr[$];
  int                seen_done = 0;

  always @(negedge clk) begin
    bit e_gnt, e_req, e_done, granted, resp;
    int old_pend;
    #1;
    mcyc++;
    e_gnt  = (ph == M_IDLE) && prefetch_req && !prefetch_abort;
    e_req  = (ph == M_ISSUE) && (m_pend < MAXO);
    e_done = (ph == M_DRAIN) && (done_at == mcyc);
    check("prefetch_gnt", 32'(prefetch_gnt), 32'(e_gnt));
    check("prefetch_busy", 32'(prefetch_busy), 32'(ph != M_IDLE));
    check("l2_req", 32'(l2_req), 32'(e_req));
    check("prefetch_done", 32'(prefetch_done), 32'(e_done));
    check("prefetch_r_valid", 32'(prefetch_r_valid), 32'(m_rv));
    check("prefetch_r_data", prefetch_r_data, m_rd);
    if (e_req) check("l2_addr", 32'(l2_addr), 32'(word_addr(m_line, m_grants)));
    check("outstanding_bound", 32'(l2_q.size() > MAXO), 32'd0);

    if (prefetch_r_valid) seen_words.push_back(prefetch_r_data);
    if (prefetch_done) seen_done++;
    if (l2_req && l2_gnt && !rst) seen_addr.push_back(l2_addr);

    if (rst) begin
      ph = M_IDLE; m_pend = 0; m_rv = 0; m_rd = '0; done_at = -1;
      m_dones = 0; m_aborts = 0;
    end else begin
      granted  = e_req && l2_gnt;
      resp     = l2_r_valid && (m_pend > 0);
      old_pend = m_pend;
      m_pend   = m_pend + int'(granted) - int'(resp);
      m_rv     = 0;
      case (ph)
        M_IDLE: if (e_gnt) begin
          m_line = prefetch_addr[ADDR_W-1:6];
          m_grants = 0; m_rets = 0; ph = M_ISSUE;
        end
        M_ISSUE, M_DRAIN: begin
          if (prefetch_abort) begin
            ph = M_FLUSH; done_at = -1; m_aborts++;
          end else begin
            if (ph == M_DRAIN && e_done) begin
              ph = M_IDLE; done_at = -1; m_dones++;
            end else if (ph == M_DRAIN && m_rets == 16 && done_at < 0) begin
              done_at = mcyc + 1;   // 16th word is visible now; done follows next cycle
            end
            if (resp) begin
              m_rv = 1;
              m_rd = l2_word(word_addr(m_line, m_rets));
              m_rets++;
            end
            if (ph == M_ISSUE) begin
              if (granted) m_grants++;
              if (m_grants == 16) ph = M_DRAIN;
            end
          end
        end
        M_FLUSH: if (old_pend == 0 && !l2_r_valid) ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic clear_seen();
    seen_words.delete();
    seen_addr.delete();
    seen_done = 0;
  endtask

  task automatic start_line(input logic [ADDR_W-1:0] a);
    bit ok;
    ok = 0;
    drv_req = 1; drv_addr = a;
    d_grants = 0; d_rets = 0; abort_fired = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (prefetch_gnt) begin ok = 1; break; end
    end
    drv_req = 0;
    if (!ok) begin n_chk++; $display("FAIL start_line: no grant for addr %h", a); end
  endtask

  task automatic wait_idle(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!prefetch_busy) return;
    end
    n_chk++;
    $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, bound);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(prefetch_busy), 32'd0);
    check({tag, "_r_valid"}, 32'(prefetch_r_valid), 32'd0);
    check({tag, "_r_data"}, prefetch_r_data, 32'd0);
    check({tag, "_done"}, 32'(prefetch_done), 32'd0);
    check({tag, "_l2_req"}, 32'(l2_req), 32'd0);
    check({tag, "_l2_addr"}, 32'(l2_addr), 32'd0);
  endtask

  initial begin
    drv_rst = 1;
    repeat (3) tick();
    drv_rst = 0;
    tick();
    check_reset_outputs("reset");
    check("reset_gnt", 32'(prefetch_gnt), 32'd0);

    // Single line, 1-cycle latency: grant and response coincide every cycle.
    idx_data = 1; gnt_pct = 100; lat_min = 1; lat_max = 1;
    clear_seen();
    start_line(19'h01240);
    wait_idle(200, "single_line");
    $display("single line: %0d words, %0d done", seen_words.size(), seen_done);
    check("single_nwords", 32'(seen_words.size()), 32'd16);
    check("single_naddr", 32'(seen_addr.size()), 32'd16);
    if (seen_words.size() == 16)
      for (int k = 0; k < 16; k++) check("single_word", seen_words[k], 32'(k));
    if (seen_addr.size() == 16) begin
      check("single_first_addr", 32'(seen_addr[0]), 32'h01240);
      check("single_last_addr", 32'(seen_addr[15]), 32'h0127C);
    end
    check("single_done", 32'(seen_done), 32'd1);

    // Outstanding limit with 10-cycle latency.
    idx_data = 0; lat_min = 10; lat_max = 10; max_pend = 0;
    clear_seen();
    start_line(19'h5A3C0);
    wait_idle(400, "outstanding");
    $display("outstanding: max pending %0d, %0d words", max_pend, seen_words.size());
    check("max_outstanding", 32'(max_pend), 32'd4);
    check("outstanding_nwords", 32'(seen_words.size()), 32'd16);
    check("outstanding_done", 32'(seen_done), 32'd1);

    // Abort after 6 grants with 3 returned.
    lat_min = 3; lat_max = 3; abort_mode = 1;
    clear_seen();
    start_line(19'h00040);
    wait_idle(200, "abort");
    abort_mode = 0;
    $display("abort: %0d grants, %0d words, %0d done", d_grants, seen_words.size(), seen_done);
    check("abort_grants", 32'(d_grants), 32'd6);
    check("abort_nwords", 32'(seen_words.size()), 32'd3);
    check("abort_done", 32'(seen_done), 32'd0);

    // Abort coincident with the 16th response.
    lat_min = 2; lat_max = 2; abort_mode = 2;
    clear_seen();
    start_line(19'h7FFC0);
    wait_idle(200, "abort_last");
    abort_mode = 0;
    $display("abort on last: %0d words, %0d done", seen_words.size(), seen_done);
    check("abort_last_nwords", 32'(seen_words.size()), 32'd15);
    check("abort_last_done", 32'(seen_done), 32'd0);

    // Abort in IDLE with a request pending.
    drv_req = 1; drv_abort = 1; drv_addr = 19'h01240;
    tick();
    $display("idle abort: gnt=%0d", prefetch_gnt);
    check("idle_abort_gnt", 32'(prefetch_gnt), 32'd0);
    drv_req = 0; drv_abort = 0;
    tick();
    check("idle_abort_busy", 32'(prefetch_busy), 32'd0);

    // Reset in DRAIN, then a normal line.
    lat_min = 10; lat_max = 10;
    start_line(19'h12340);
    for (int i = 0; i < 300 && d_grants < 16; i++) tick();
    tick();
    check("drain_busy", 32'(prefetch_busy), 32'd1);
    check("drain_l2_req", 32'(l2_req), 32'd0);
    drv_rst = 1;
    tick();
    drv_rst = 0;
    tick();
    $display("reset in drain: busy=%0d r_valid=%0d", prefetch_busy, prefetch_r_valid);
    check_reset_outputs("drain_reset");
    lat_min = 1; lat_max = 4;
    clear_seen();
    start_line(19'h2AA80);
    wait_idle(300, "after_reset");
    check("after_reset_nwords", 32'(seen_words.size()), 32'd16);
    check("after_reset_done", 32'(seen_done), 32'd1);

    // Randomized lines: grant rate, latency, aborts and idle gaps all vary.
    abort_mode = 3;
    for (int n = 0; n < 40; n++) begin
      gnt_pct   = int'($urandom_range(100, 30));
      lat_min   = 1;
      lat_max   = int'($urandom_range(12, 1));
      abort_pct = (n % 3 == 0) ? 3 : 0;
      repeat (int'($urandom_range(3, 0))) tick();
      clear_seen();
      start_line(ADDR_W'($urandom));
      wait_idle(3000, "random_line");
      $display("random line %0d: gnt%%=%0d lat<=%0d words=%0d done=%0d",
               n, gnt_pct, lat_max, seen_words.size(), seen_done);
    end
    abort_mode = 0;
    repeat (3) tick();

`ifdef PREFETCH_PERF_CNT_EN
    check("perf_lines_done", perf_lines_done, 32'(m_dones));
    check("perf_lines_aborted", perf_lines_aborted, 32'(m_aborts));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
